// File: rtl/dds_tune_ctrl_if.sv
// Handshake bundle between the frequency comparator and the DDS tuning controller.
// The comparator side drives window position and verdicts; the controller side
// returns the synthesized clock, tuning word and loop status.
interface dds_tune_ctrl_if #(
    parameter int unsigned ACC_W = 24
);
    logic             Enable;
    logic [7:0]       Time_Frame;
    logic             Slow;
    logic             Fast;
    logic             DDS_Out;
    logic [ACC_W-1:0] FTW;
    logic             Tune_Valid;
    logic             Locked;
    logic [1:0]       State;

    modport master (
        output Enable, Time_Frame, Slow, Fast,
        input  DDS_Out, FTW, Tune_Valid, Locked, State
    );

    modport slave (
        input  Enable, Time_Frame, Slow, Fast,
        output DDS_Out, FTW, Tune_Valid, Locked, State
    );
endinterface

// File: rtl/dds_tune_ctrl.sv
// DDS tuning controller: turns per-window Slow/Fast verdicts into tuning-word
// updates (binary-step acquisition, unit-step tracking, lock detection) and runs
// the phase accumulator whose MSB is DDS_Out.
// Optional build macro DDS_DITHER_EN adds LFSR dither to the accumulator increment.
module dds_tune_ctrl #(
    parameter int unsigned      ACC_W     = 24,
    parameter logic [ACC_W-1:0] FTW_INIT  = 24'h100000,
    parameter logic [ACC_W-1:0] FTW_MIN   = 24'h000100,
    parameter logic [ACC_W-1:0] FTW_MAX   = 24'h7FFFFF,
    parameter logic [ACC_W-1:0] STEP_INIT = 24'h010000,
    parameter int unsigned      LOCK_CNT  = 4,
    parameter logic [7:0]       SAMPLE_TF = 8'd35
) (
    input logic             REF_Clk,
    input logic             Reset_N,
    dds_tune_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DN   = 2'd2;

    localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);
    localparam logic [ACC_W-1:0] OneStep = ACC_W'(1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [3:0]       bal_q, bal_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       tf_q, tf_d;
    logic             locked_q, locked_d;
    logic             valid_q, valid_d;

    logic             sample_evt, v_up, v_dn, v_bal, reverse;
    logic [ACC_W-1:0] step_half, step_eff;
    logic [3:0]       bal_inc;

    // Move the tuning word by delta, saturating to [FTW_MIN, FTW_MAX] instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_step(input logic [ACC_W-1:0] base,
                                                  input logic [ACC_W-1:0] delta,
                                                  input logic             up);
        logic [ACC_W:0] r;
        if (up) begin
            r = {1'b0, base} + {1'b0, delta};
            if (r > {1'b0, FTW_MAX}) return FTW_MAX;
        end else begin
            r = {1'b0, base} - {1'b0, delta};
            // bit ACC_W set means the subtraction borrowed (went negative)
            if (r[ACC_W] || (r < {1'b0, FTW_MIN})) return FTW_MIN;
        end
        return r[ACC_W-1:0];
    endfunction

    // Sample-edge detect and verdict decode.
    always_comb begin
        tf_d       = bus.Time_Frame;
        sample_evt = (bus.Time_Frame == SAMPLE_TF) && (tf_q != SAMPLE_TF);
        v_up       = bus.Slow & ~bus.Fast;
        v_dn       = bus.Fast & ~bus.Slow;
        v_bal      = ~bus.Slow & ~bus.Fast;
        reverse    = (v_up && (dir_q == DIR_DN)) || (v_dn && (dir_q == DIR_UP));
        step_half  = (step_q > OneStep) ? (step_q >> 1) : OneStep;
        step_eff   = reverse ? step_half : step_q;
        bal_inc    = (bal_q == 4'hF) ? bal_q : bal_q + 4'd1;
    end

    // Tuning state machine; Tune_Valid marks every processed sample event.
    always_comb begin
        state_d  = state_q;
        ftw_d    = ftw_q;
        step_d   = step_q;
        bal_d    = bal_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        if ((state_q != ST_IDLE) && !bus.Enable) begin
            // Dropping Enable wins over a coincident sample event.
            state_d  = ST_IDLE;
            locked_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (bus.Enable) begin
                state_d = ST_ACQ;
                step_d  = STEP_INIT;
                dir_d   = DIR_NONE;
                bal_d   = 4'd0;
            end
        end else if (sample_evt) begin
            valid_d = 1'b1;
            case (state_q)
                ST_ACQ: begin
                    if (v_up || v_dn) begin
                        step_d = step_eff;
                        ftw_d  = sat_step(ftw_q, step_eff, v_up);
                        dir_d  = v_up ? DIR_UP : DIR_DN;
                        bal_d  = 4'd0;
                    end else if (v_bal) begin
                        bal_d = bal_inc;
                    end else begin
                        bal_d = 4'd0;
                    end
                    if (step_d == OneStep) begin
                        state_d = ST_TRACK;
                        bal_d   = 4'd0;
                    end
                end
                ST_TRACK: begin
                    if (v_up || v_dn) begin
                        ftw_d = sat_step(ftw_q, OneStep, v_up);
                        bal_d = 4'd0;
                    end else if (v_bal) begin
                        bal_d = bal_inc;
                        if (bal_inc >= LockCnt) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        bal_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (v_up || v_dn) begin
                        ftw_d    = sat_step(ftw_q, OneStep, v_up);
                        state_d  = ST_TRACK;
                        locked_d = 1'b0;
                        bal_d    = 4'd0;
                    end else if (!v_bal) begin
                        bal_d = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DDS_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; low nibble dithers the phase increment.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        acc_d  = acc_q + ftw_q + {{(ACC_W-4){1'b0}}, lfsr_q[3:0]};
    end

    // Dither generator state.
    always_ff @(posedge REF_Clk) begin
        if (!Reset_N) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
`else
    // Plain phase accumulator step.
    always_comb begin
        acc_d = acc_q + ftw_q;
    end
`endif

    // Controller and accumulator state; reset is synchronous.
    always_ff @(posedge REF_Clk) begin
        if (!Reset_N) begin
            acc_q    <= '0;
            ftw_q    <= FTW_INIT;
            step_q   <= STEP_INIT;
            bal_q    <= 4'd0;
            dir_q    <= DIR_NONE;
            state_q  <= ST_IDLE;
            tf_q     <= 8'd0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ftw_q    <= ftw_d;
            step_q   <= step_d;
            bal_q    <= bal_d;
            dir_q    <= dir_d;
            state_q  <= state_d;
            tf_q     <= tf_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
        end
    end

    // Output mapping.
    always_comb begin
        bus.DDS_Out    = acc_q[ACC_W-1];
        bus.FTW        = ftw_q;
        bus.Tune_Valid = valid_q;
        bus.Locked     = locked_q;
        bus.State      = state_q;
    end

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Bench for dds_tune_ctrl: four instances with different FTW_INIT/STEP_INIT share
// one stimulus stream; each is compared every cycle with an integer reference model,
// plus a directed vector table and hand sequences for clamp, lock, disable and reset.
module tb_dds_tune_ctrl;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_in = 1'b0;
    logic [7:0] tf_in = 8'd0;
    logic       slow_in = 1'b0;
    logic       fast_in = 1'b0;

    logic [23:0] ftw_o [NI];
    logic [1:0]  st_o  [NI];
    logic        dds_o [NI];
    logic        tv_o  [NI];
    logic        lk_o  [NI];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic int cfg_init(input int i);
        case (i)
            1:       return 32'h400000;
            2:       return 32'h7FF000;
            default: return 32'h100000;
        endcase
    endfunction

    function automatic int cfg_step(input int i);
        return (i == 3) ? 1 : 32'h010000;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dds_tune_ctrl_if bus ();
        assign bus.Enable     = enable_in;
        assign bus.Time_Frame = tf_in;
        assign bus.Slow       = slow_in;
        assign bus.Fast       = fast_in;
        assign ftw_o[g] = bus.FTW;
        assign st_o[g]  = bus.State;
        assign dds_o[g] = bus.DDS_Out;
        assign tv_o[g]  = bus.Tune_Valid;
        assign lk_o[g]  = bus.Locked;
        dds_tune_ctrl #(
            .FTW_INIT (24'(cfg_init(g))),
            .STEP_INIT(24'(cfg_step(g)))
        ) u_dut (
            .REF_Clk(clk),
            .Reset_N(rst_n),
            .bus    (bus)
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (integer arithmetic) ----------------
    int m_ftw [NI], m_step [NI], m_bal [NI], m_dir [NI], m_st [NI], m_lk [NI], m_tv [NI];
    int m_acc [NI];
    int m_tfprev = 0;

    function automatic int sat(input int x);
        if (x > 32'h7FFFFF) return 32'h7FFFFF;
        if (x < 32'h100) return 32'h100;
        return x;
    endfunction

    task automatic model_apply(input int i, input int v);
        bit mv;
        mv = (v == 1) || (v == -1);
        case (m_st[i])
            1: begin
                if (mv) begin
                    if (m_dir[i] != 0 && m_dir[i] != v)
                        m_step[i] = (m_step[i] > 1) ? m_step[i] / 2 : 1;
                    m_ftw[i] = sat(m_ftw[i] + v * m_step[i]);
                    m_dir[i] = v;
                    m_bal[i] = 0;
                end else if (v == 0) begin
                    m_bal[i] = (m_bal[i] < 15) ? m_bal[i] + 1 : 15;
                end else begin
                    m_bal[i] = 0;
                end
                if (m_step[i] == 1) begin
                    m_st[i] = 2;
                    m_bal[i] = 0;
                end
            end
            2: begin
                if (mv) begin
                    m_ftw[i] = sat(m_ftw[i] + v);
                    m_bal[i] = 0;
                end else if (v == 0) begin
                    m_bal[i]++;
                    if (m_bal[i] >= 4) begin
                        m_st[i] = 3;
                        m_lk[i] = 1;
                    end
                end else begin
                    m_bal[i] = 0;
                end
            end
            3: begin
                if (mv) begin
                    m_ftw[i] = sat(m_ftw[i] + v);
                    m_st[i] = 2;
                    m_lk[i] = 0;
                    m_bal[i] = 0;
                end else if (v != 0) begin
                    m_bal[i] = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        bit evt;
        int v;
        evt = (tf_in == 8'd35) && (m_tfprev != 35);
        if (slow_in && !fast_in)      v = 1;
        else if (fast_in && !slow_in) v = -1;
        else if (!slow_in && !fast_in) v = 0;
        else                          v = 2;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_acc[i] = 0; m_ftw[i] = cfg_init(i); m_step[i] = cfg_step(i);
                m_bal[i] = 0; m_dir[i] = 0; m_st[i] = 0; m_lk[i] = 0; m_tv[i] = 0;
            end else begin
                m_acc[i] = (m_acc[i] + m_ftw[i]) % (1 << 24);
                m_tv[i] = 0;
                if (m_st[i] != 0 && !enable_in) begin
                    m_st[i] = 0;
                    m_lk[i] = 0;
                end else if (m_st[i] == 0) begin
                    if (enable_in) begin
                        m_st[i] = 1; m_step[i] = cfg_step(i); m_dir[i] = 0; m_bal[i] = 0;
                    end
                end else if (evt) begin
                    m_tv[i] = 1;
                    model_apply(i, v);
                end
            end
        end
        m_tfprev = rst_n ? int'(tf_in) : 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model[%0d].FTW", i), int'(ftw_o[i]), m_ftw[i]);
                chk($sformatf("model[%0d].State", i), int'(st_o[i]), m_st[i]);
                chk($sformatf("model[%0d].Locked", i), int'(lk_o[i]), m_lk[i]);
                chk($sformatf("model[%0d].Tune_Valid", i), int'(tv_o[i]), m_tv[i]);
                chk($sformatf("model[%0d].DDS_Out", i), int'(dds_o[i]), (m_acc[i] >> 23) & 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step_in(input bit en, input logic [7:0] tf, input bit s, input bit f);
        enable_in = en; tf_in = tf; slow_in = s; fast_in = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic window(input bit s, input bit f);
        step_in(1'b1, 8'd0, s, f);
        step_in(1'b1, 8'd35, s, f);
    endtask

    typedef struct {
        bit          en;
        logic [7:0]  tf;
        bit          s;
        bit          f;
        logic [23:0] ftw;
        int          st;
        bit          tv;
    } vec_t;

    vec_t tab [13];

    initial begin
        int tfc;
        int r;
        tab[0]  = '{1'b1, 8'd0,  1'b0, 1'b0, 24'h100000, 1, 1'b0};
        tab[1]  = '{1'b1, 8'd34, 1'b1, 1'b0, 24'h100000, 1, 1'b0};
        tab[2]  = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h110000, 1, 1'b1};
        tab[3]  = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h110000, 1, 1'b0};
        tab[4]  = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h110000, 1, 1'b0};
        tab[5]  = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h110000, 1, 1'b0};
        tab[6]  = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h110000, 1, 1'b0};
        tab[7]  = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h110000, 1, 1'b0};
        tab[8]  = '{1'b1, 8'd0,  1'b0, 1'b1, 24'h110000, 1, 1'b0};
        tab[9]  = '{1'b1, 8'd35, 1'b0, 1'b1, 24'h108000, 1, 1'b1};
        tab[10] = '{1'b1, 8'd0,  1'b1, 1'b0, 24'h108000, 1, 1'b0};
        tab[11] = '{1'b1, 8'd35, 1'b1, 1'b0, 24'h10C000, 1, 1'b1};
        tab[12] = '{1'b1, 8'd0,  1'b0, 1'b0, 24'h10C000, 1, 1'b0};

        // Reset held for two edges.
        step_in(1'b0, 8'd0, 1'b0, 1'b0);
        step_in(1'b0, 8'd0, 1'b0, 1'b0);
        chk("reset.FTW", int'(ftw_o[0]), 32'h100000);
        chk("reset.DDS_Out", int'(dds_o[0]), 0);
        chk("reset.Locked", int'(lk_o[0]), 0);
        chk("reset.State", int'(st_o[0]), 0);
        chk("reset.Tune_Valid", int'(tv_o[0]), 0);
        chk("reset.FTW_override", int'(ftw_o[1]), 32'h400000);
        chk_en = 1'b1;

        // FTW=0x400000 gives a 0,0,1,1 DDS_Out pattern from the reset value on.
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step_in(1'b0, 8'd0, 1'b0, 1'b0);
            chk($sformatf("dds_pattern[%0d]", k), int'(dds_o[1]), ((k % 4) >= 2) ? 1 : 0);
        end

        // Directed acquisition table on the default instance.
        foreach (tab[n]) begin
            step_in(tab[n].en, tab[n].tf, tab[n].s, tab[n].f);
            chk($sformatf("tab[%0d].FTW", n), int'(ftw_o[0]), int'(tab[n].ftw));
            chk($sformatf("tab[%0d].State", n), int'(st_o[0]), tab[n].st);
            chk($sformatf("tab[%0d].Tune_Valid", n), int'(tv_o[0]), int'(tab[n].tv));
        end

        // Clamp: keep pushing up; the near-max instance must pin at FTW_MAX.
        for (int k = 0; k < 4; k++) window(1'b1, 1'b0);
        chk("clamp.FTW_max", int'(ftw_o[2]), 32'h7FFFFF);
        chk("clamp.FTW_default", int'(ftw_o[0]), 32'h11C000);
        window(1'b1, 1'b1);
        chk("illegal.FTW", int'(ftw_o[2]), 32'h7FFFFF);
        chk("illegal.Tune_Valid", int'(tv_o[2]), 1);

        // Lock sequence on the STEP_INIT=1 instance.
        rst_n = 1'b0;
        step_in(1'b0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step_in(1'b1, 8'd0, 1'b0, 1'b0);
        chk("lock.enter_acq", int'(st_o[3]), 1);
        window(1'b1, 1'b0);
        chk("lock.up_FTW", int'(ftw_o[3]), 32'h100001);
        chk("lock.up_State", int'(st_o[3]), 2);
        for (int k = 0; k < 3; k++) window(1'b0, 1'b0);
        chk("lock.bal3_Locked", int'(lk_o[3]), 0);
        window(1'b0, 1'b0);
        chk("lock.bal4_Locked", int'(lk_o[3]), 1);
        chk("lock.bal4_State", int'(st_o[3]), 3);
        chk("lock.bal4_FTW", int'(ftw_o[3]), 32'h100001);
        window(1'b0, 1'b1);
        chk("unlock.FTW", int'(ftw_o[3]), 32'h100000);
        chk("unlock.Locked", int'(lk_o[3]), 0);
        chk("unlock.State", int'(st_o[3]), 2);
        for (int k = 0; k < 4; k++) window(1'b0, 1'b0);
        chk("relock.State", int'(st_o[3]), 3);

        // Disable while locked.
        step_in(1'b0, 8'd0, 1'b0, 1'b0);
        chk("disable.State", int'(st_o[3]), 0);
        chk("disable.Locked", int'(lk_o[3]), 0);
        chk("disable.FTW", int'(ftw_o[3]), 32'h100000);

        // Reset coincident with a sample event discards the decision.
        step_in(1'b1, 8'd0, 1'b0, 1'b0);
        step_in(1'b1, 8'd34, 1'b1, 1'b0);
        rst_n = 1'b0;
        step_in(1'b1, 8'd35, 1'b1, 1'b0);
        chk("rst_evt.FTW", int'(ftw_o[0]), 32'h100000);
        chk("rst_evt.Tune_Valid", int'(tv_o[0]), 0);
        chk("rst_evt.State", int'(st_o[0]), 0);
        rst_n = 1'b1;

        // Randomized run, checked cycle by cycle against the model.
        tfc = 0;
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            enable_in = ($urandom_range(0, 149) != 0);
            r = $urandom_range(0, 6);
            if (r != 0) tfc = (tfc + 1) % 40;
            if (r == 6 && tfc == 35) tfc = 35;
            tf_in = 8'(tfc);
            r = $urandom_range(0, 9);
            slow_in = (r == 4 || r == 5 || r == 8);
            fast_in = (r == 6 || r == 7 || r == 8);
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_tune_ctrl.md
Name: dds_tune_ctrl

Overview:
- Correction end of the frequency-compare loop: consumes per-window Slow/Fast verdicts from the frequency comparator and steers a phase-accumulator DDS whose output, DDS_Out, feeds back into that comparator.
- Tuning-word search: binary-step acquisition, then unit-step tracking, then lock detect.
- Everything runs in the REF_Clk domain.

Parameters:
- ACC_W, 24, phase accumulator and tuning word width (bits)
- FTW_INIT, 24'h100000, tuning word after reset
- FTW_MIN, 24'h000100, lower clamp for FTW
- FTW_MAX, 24'h7FFFFF, upper clamp for FTW (keeps DDS_Out below REF_Clk/2)
- STEP_INIT, 24'h010000, first acquisition step
- LOCK_CNT, 4, consecutive balanced windows required to declare lock (range 1..15)
- SAMPLE_TF, 8'd35, Time_Frame value at which the verdict is sampled (must lie in 31..40)

Ports:
- REF_Clk  in  1  reference clock; sole clock
- Reset_N  in  1  synchronous, active-low reset
- Enable  in  1  tuning enable
- Time_Frame  in  8  window position from the comparator
- Slow  in  1  DDS slower than reference in the last window
- Fast  in  1  DDS faster than reference in the last window
- DDS_Out  out  1  accumulator MSB, synthesized clock
- FTW  out  ACC_W  current tuning word
- Tune_Valid  out  1  one-cycle pulse when FTW/state is updated
- Locked  out  1  lock indicator
- State  out  2  0 IDLE, 1 ACQ, 2 TRACK, 3 LOCKED

Behaviour:
- Reset (Reset_N low at a REF_Clk edge) takes effect on that same edge:
  - FTW=FTW_INIT, accumulator=0, DDS_Out=0, Tune_Valid=0, Locked=0, State=IDLE.
  - Step=STEP_INIT, balance count=0, last direction=none, sample-edge register cleared.
  - Reset mid-window or mid-update discards any pending decision.
- Accumulator:
  - acc <= acc + FTW every cycle, modulo 2^ACC_W.
  - DDS_Out = acc[ACC_W-1].
  - Runs in all states, including IDLE.
- Sample event:
  - Fires the first cycle Time_Frame==SAMPLE_TF while the previous cycle's Time_Frame!=SAMPLE_TF.
  - A Time_Frame that stays parked at SAMPLE_TF produces no repeat events.
- Verdict decode, using Slow/Fast captured on the sample cycle:
  - UP = Slow & ~Fast
  - DN = Fast & ~Slow
  - BAL = ~Slow & ~Fast
  - Slow&Fast (illegal) = no change; resets the balance count; does not alter last direction.
- Latency: FTW, State, Locked and Tune_Valid update exactly 1 cycle after the sample cycle. Tune_Valid pulses on every processed sample event, including no-change.
- IDLE:
  - Sample events are ignored.
  - Enable=1 moves to ACQ with Step=STEP_INIT, last direction=none, balance count=0. FTW is retained.
- ACQ:
  - UP: FTW += Step. DN: FTW -= Step.
  - If the direction is opposite to the last direction, Step is first halved: Step=max(Step>>1,1). The FTW change uses the halved step.
  - When Step reaches 1, go to TRACK.
  - BAL: FTW unchanged; balance count increments.
- TRACK:
  - UP/DN: FTW +/-1; balance count=0.
  - BAL: balance count+1. When it reaches LOCK_CNT, go to LOCKED with Locked=1.
- LOCKED:
  - BAL: hold.
  - UP/DN: FTW +/-1, State=TRACK, Locked=0 and balance count=0 in the same update.
- Arithmetic: computed in ACC_W+1 bits and saturated. Result >FTW_MAX gives FTW_MAX; result <FTW_MIN gives FTW_MIN. No wrap.
- Enable=0 in any non-IDLE state: next cycle State=IDLE, Locked=0. FTW is held. A sample event coincident with Enable falling is discarded.
- STEP_INIT=1: Enable enters ACQ, and the first processed verdict moves to TRACK.

Optional Feature:
- Macro: DDS_DITHER_EN.
- When defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle.
  - Its low 4 bits are added to the accumulator increment: acc <= acc + FTW + lfsr[3:0]. This breaks up DDS_Out spurs.
  - FTW output is unaffected.
- When undefined: no LFSR logic; accumulator is exactly acc+FTW.

Test Plan:
- Reset: Reset_N=0 for 2 edges -> FTW=24'h100000, DDS_Out=0, Locked=0, State=0, Tune_Valid=0. Then force FTW=24'h400000 (FTW_INIT override) -> DDS_Out pattern 0,0,1,1 repeating (period 4 cycles).
- Acquire up: Enable=1, Slow=1, Time_Frame steps 34->35 -> one cycle later FTW=24'h110000, Tune_Valid=1 for one cycle, State=1. Time_Frame held at 35 for 5 cycles -> no further update.
- Reversal: after the above, next window Fast=1 -> Step=24'h008000, FTW=24'h108000. Next window Slow=1 -> Step=24'h004000, FTW=24'h10C000.
- Clamp: FTW_INIT=24'h7FF000, STEP_INIT=24'h010000, Slow every window -> FTW=24'h7FFFFF, never wraps. Slow&Fast window -> FTW unchanged.
- Lock: STEP_INIT=1, Enable=1; windows UP then 4 BAL -> FTW=FTW_INIT+1, Locked=1 after 4th BAL, State=3. Then Fast -> FTW=FTW_INIT, Locked=0, State=2.
- Reset/disable mid-run: in LOCKED, Enable=0 -> State=0, Locked=0, FTW held. Reset_N=0 coincident with a sample event -> FTW=FTW_INIT, no Tune_Valid pulse.
